// File: rtl/hazard_tracker.sv
// Hazard tracker: E/M/W destination/Tnew scoreboard producing Stall and forwarding selects.
// Zero-latency combinational outputs; Stall freezes D and injects an E bubble, no other backpressure.
module hazard_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic [4:0]  D_A3,
  input  logic        D_A1use,
  input  logic        D_A2use,
  input  logic [3:0]  D_rs_Tuse,
  input  logic [3:0]  D_rt_Tuse,
  input  logic [3:0]  D_Tnew,
  output logic        Stall,
  output logic [1:0]  Fwd_D_rs,
  output logic [1:0]  Fwd_D_rt,
  output logic [1:0]  Fwd_E_rs,
  output logic [1:0]  Fwd_E_rt,
  output logic        Fwd_M_rt,
  output logic [4:0]  E_A3,
  output logic [4:0]  M_A3,
  output logic [4:0]  W_A3,
  output logic [15:0] Stall_Count
);

  // M_A1, W_A1 and W_A2 are never consulted by any select, so they are not stored.
  logic [4:0]  e_a1_q, e_a2_q, e_a3_q, m_a2_q, m_a3_q, w_a3_q;
  logic [4:0]  e_a1_d, e_a2_d, e_a3_d, m_a2_d, m_a3_d, w_a3_d;
  logic [3:0]  e_tnew_q, m_tnew_q, w_tnew_q;
  logic [3:0]  e_tnew_d, m_tnew_d, w_tnew_d;
  logic [15:0] cnt_q, cnt_d;

  function automatic logic [3:0] sat_dec(input logic [3:0] x);
    return (x == 4'd0) ? 4'd0 : x - 4'd1;
  endfunction

  function automatic logic hit(input logic [4:0] a, input logic [4:0] dst);
    return (a != 5'd0) && (a == dst);
  endfunction

  // Youngest ready producer wins: E (3) over M (2) over W (1).
  function automatic logic [1:0] fwd_d(input logic [4:0] a);
    if (hit(a, e_a3_q) && e_tnew_q == 4'd0)      return 2'd3;
    else if (hit(a, m_a3_q) && m_tnew_q == 4'd0) return 2'd2;
    else if (hit(a, w_a3_q) && w_tnew_q == 4'd0) return 2'd1;
    else                                         return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] a);
    if (hit(a, m_a3_q) && m_tnew_q == 4'd0)      return 2'd2;
    else if (hit(a, w_a3_q) && w_tnew_q == 4'd0) return 2'd1;
    else                                         return 2'd0;
  endfunction

  logic rs_hit_e, rs_hit_m, rt_hit_e, rt_hit_m;

  always_comb begin
    rs_hit_e = D_A1use && hit(D_A1, e_a3_q);
    rs_hit_m = D_A1use && hit(D_A1, m_a3_q);
    rt_hit_e = D_A2use && hit(D_A2, e_a3_q);
    rt_hit_m = D_A2use && hit(D_A2, m_a3_q);

    // W always has its result ready, so only E and M can stall D.
    Stall = (rs_hit_e && (e_tnew_q > D_rs_Tuse)) ||
            (rs_hit_m && (m_tnew_q > D_rs_Tuse)) ||
            (rt_hit_e && (e_tnew_q > D_rt_Tuse)) ||
            (rt_hit_m && (m_tnew_q > D_rt_Tuse));

    Fwd_D_rs = fwd_d(D_A1);
    Fwd_D_rt = fwd_d(D_A2);
    Fwd_E_rs = fwd_e(e_a1_q);
    Fwd_E_rt = fwd_e(e_a2_q);
    Fwd_M_rt = hit(m_a2_q, w_a3_q);

    E_A3        = e_a3_q;
    M_A3        = m_a3_q;
    W_A3        = w_a3_q;
    Stall_Count = cnt_q;
  end

  always_comb begin
    e_a1_d   = 5'd0;
    e_a2_d   = 5'd0;
    e_a3_d   = 5'd0;
    e_tnew_d = 4'd0;
    if (!Stall) begin
      e_a1_d   = D_A1;
      e_a2_d   = D_A2;
      e_a3_d   = D_A3;
      e_tnew_d = sat_dec(D_Tnew);
    end
    m_a2_d   = e_a2_q;
    m_a3_d   = e_a3_q;
    m_tnew_d = sat_dec(e_tnew_q);
    w_a3_d   = m_a3_q;
    w_tnew_d = sat_dec(m_tnew_q);
    cnt_d    = cnt_q;
    if (Stall && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_a1_q   <= 5'd0;
      e_a2_q   <= 5'd0;
      e_a3_q   <= 5'd0;
      e_tnew_q <= 4'd0;
      m_a2_q   <= 5'd0;
      m_a3_q   <= 5'd0;
      m_tnew_q <= 4'd0;
      w_a3_q   <= 5'd0;
      w_tnew_q <= 4'd0;
      cnt_q    <= 16'd0;
    end else begin
      e_a1_q   <= e_a1_d;
      e_a2_q   <= e_a2_d;
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      m_a2_q   <= m_a2_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= w_a3_d;
      w_tnew_q <= w_tnew_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboarded bench: an instruction-history model predicts every output each cycle,
// and a negedge monitor pops and compares those predictions against the tracker.
module tb_hazard_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_A1, D_A2, D_A3;
  logic        D_A1use, D_A2use;
  logic [3:0]  D_rs_Tuse, D_rt_Tuse, D_Tnew;
  logic        Stall;
  logic [1:0]  Fwd_D_rs, Fwd_D_rt, Fwd_E_rs, Fwd_E_rt;
  logic        Fwd_M_rt;
  logic [4:0]  E_A3, M_A3, W_A3;
  logic [15:0] Stall_Count;

  hazard_tracker dut (
    .clk(clk), .reset(reset),
    .D_A1(D_A1), .D_A2(D_A2), .D_A3(D_A3),
    .D_A1use(D_A1use), .D_A2use(D_A2use),
    .D_rs_Tuse(D_rs_Tuse), .D_rt_Tuse(D_rt_Tuse), .D_Tnew(D_Tnew),
    .Stall(Stall),
    .Fwd_D_rs(Fwd_D_rs), .Fwd_D_rt(Fwd_D_rt),
    .Fwd_E_rs(Fwd_E_rs), .Fwd_E_rt(Fwd_E_rt), .Fwd_M_rt(Fwd_M_rt),
    .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
    .Stall_Count(Stall_Count)
  );

  always #5 clk = ~clk;

  // hist[k] is the instruction that left D k cycles ago (1=E, 2=M, 3=W); bubbles are all-zero.
  typedef struct packed {
    logic [4:0] a1, a2, a3;
    logic [3:0] tnew0;
  } ent_t;

  typedef struct {
    int stall, fdrs, fdrt, fers, fert, fmrt, ea3, ma3, wa3, cnt;
  } exp_t;

  ent_t hist [1:3];
  int   m_cnt   = 0;
  int   m_stall = 0;
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic int tn(int k);
    int t;
    t = int'(hist[k].tnew0) - k;
    return (t > 0) ? t : 0;
  endfunction

  function automatic int fwd_from(int a, int first);
    for (int k = first; k <= 3; k++)
      if (a != 0 && a == int'(hist[k].a3) && tn(k) == 0) return 4 - k;
    return 0;
  endfunction

  function automatic int stall_of(int a, int use_it, int tuse);
    int s;
    s = 0;
    for (int k = 1; k <= 2; k++)
      if (use_it != 0 && a != 0 && a == int'(hist[k].a3) && tn(k) > tuse) s = 1;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: retire the model state for the edge, then drive new D inputs and predict.
  task automatic cycle(input int a1, input int a2, input int a3, input int u1, input int u2,
                       input int trs, input int trt, input int tnew, input int rst);
    ent_t e;
    exp_t x;
    @(posedge clk);
    if (!reset) begin
      for (int k = 1; k <= 3; k++) hist[k] = '0;
      m_cnt = 0;
    end else begin
      e = '{a1: D_A1, a2: D_A2, a3: D_A3, tnew0: D_Tnew};
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = (m_stall != 0) ? ent_t'('0) : e;
      if (m_stall != 0 && m_cnt < 65535) m_cnt++;
    end
    #1;
    reset     = rst[0];
    D_A1      = a1[4:0];
    D_A2      = a2[4:0];
    D_A3      = a3[4:0];
    D_A1use   = u1[0];
    D_A2use   = u2[0];
    D_rs_Tuse = trs[3:0];
    D_rt_Tuse = trt[3:0];
    D_Tnew    = tnew[3:0];
    m_stall = stall_of(a1, u1, trs) | stall_of(a2, u2, trt);
    x.stall = m_stall;
    x.fdrs  = fwd_from(a1, 1);
    x.fdrt  = fwd_from(a2, 1);
    x.fers  = fwd_from(int'(hist[1].a1), 2);
    x.fert  = fwd_from(int'(hist[1].a2), 2);
    x.fmrt  = (hist[2].a2 != 0 && hist[2].a2 == hist[3].a3) ? 1 : 0;
    x.ea3   = int'(hist[1].a3);
    x.ma3   = int'(hist[2].a3);
    x.wa3   = int'(hist[3].a3);
    x.cnt   = m_cnt;
    sb.push_back(x);
  endtask

  // Issue one instruction, holding it in D for as long as it is stalled.
  task automatic instr(input int a1, input int a2, input int a3, input int u1, input int u2,
                       input int trs, input int trt, input int tnew);
    int n;
    n = 0;
    do begin
      cycle(a1, a2, a3, u1, u2, trs, trt, tnew, 1);
      n++;
    end while (m_stall != 0 && n < 6);
  endtask

  task automatic nop();
    instr(0, 0, 0, 0, 0, 5, 5, 0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("Stall",       int'(Stall),       x.stall);
      chk("Fwd_D_rs",    int'(Fwd_D_rs),    x.fdrs);
      chk("Fwd_D_rt",    int'(Fwd_D_rt),    x.fdrt);
      chk("Fwd_E_rs",    int'(Fwd_E_rs),    x.fers);
      chk("Fwd_E_rt",    int'(Fwd_E_rt),    x.fert);
      chk("Fwd_M_rt",    int'(Fwd_M_rt),    x.fmrt);
      chk("E_A3",        int'(E_A3),        x.ea3);
      chk("M_A3",        int'(M_A3),        x.ma3);
      chk("W_A3",        int'(W_A3),        x.wa3);
      chk("Stall_Count", int'(Stall_Count), x.cnt);
    end
  end

  initial begin
    int a1, a2, a3, u1, u2, trs, trt, tnew, rst;
    for (int k = 1; k <= 3; k++) hist[k] = '0;
    reset = 1'b0;
    D_A1 = '0; D_A2 = '0; D_A3 = '0; D_A1use = 1'b0; D_A2use = 1'b0;
    D_rs_Tuse = 4'd5; D_rt_Tuse = 4'd5; D_Tnew = '0;

    // Reset held across two edges with junk on D; state must read back cleared.
    cycle(8, 8, 8, 1, 1, 0, 0, 3, 0);
    cycle(0, 0, 0, 0, 0, 5, 5, 0, 1);

    // lw $8 ; add rs=$8 (Tuse 1): one stall, then E-stage forward from W.
    instr(29, 0, 8, 1, 0, 1, 5, 3);
    instr(8, 9, 11, 1, 1, 1, 1, 2);
    nop(); nop(); nop();
    // add $9 ; beq rs=$9 (Tuse 0): one stall, then D forward from M.
    instr(1, 2, 9, 1, 1, 1, 1, 2);
    instr(9, 0, 0, 1, 1, 0, 0, 0);
    nop(); nop(); nop();
    // ori $10 ; lui $10 ; sw rt=$10 (rt Tuse 2): no stall, lui in M wins.
    instr(3, 0, 10, 1, 0, 1, 5, 2);
    instr(0, 0, 10, 0, 0, 5, 5, 2);
    instr(29, 10, 0, 1, 1, 1, 2, 0);
    nop(); nop(); nop();
    // add $0 ; beq $0,$0: index zero never stalls or forwards.
    instr(1, 2, 0, 1, 1, 1, 1, 2);
    instr(0, 0, 0, 1, 1, 0, 0, 0);
    nop(); nop(); nop();
    // lw $8 ; jr $8 (Tuse 0): two stalls, then forward from W.
    instr(29, 0, 8, 1, 0, 1, 5, 3);
    instr(8, 0, 0, 1, 0, 0, 5, 0);
    nop(); nop(); nop();
    // Reset asserted while jr is stalled: everything clears, jr discarded.
    instr(29, 0, 8, 1, 0, 1, 5, 3);
    cycle(8, 0, 0, 1, 0, 0, 5, 0, 1);
    cycle(8, 0, 0, 1, 0, 0, 5, 0, 0);
    nop(); nop();

    // Random traffic over a small register window so hits are frequent.
    a1 = 0; a2 = 0; a3 = 0; u1 = 0; u2 = 0; trs = 5; trt = 5; tnew = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_stall == 0) begin
        a1   = $urandom_range(0, 3);
        a2   = $urandom_range(0, 3);
        a3   = $urandom_range(0, 3);
        u1   = $urandom_range(0, 1);
        u2   = $urandom_range(0, 1);
        trs  = $urandom_range(0, 5);
        trt  = $urandom_range(0, 5);
        tnew = $urandom_range(0, 3);
      end
      rst = ($urandom_range(0, 63) == 0) ? 0 : 1;
      cycle(a1, a2, a3, u1, u2, trs, trt, tnew, rst);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled on rising clk edge only.
REQ-004 D_A1  in  5  rs index of instruction in D.
REQ-005 D_A2  in  5  rt index of instruction in D.
REQ-006 D_A3  in  5  destination index of instruction in D (0 = no write).
REQ-007 D_A1use / D_A2use  in  1 each  D instruction reads rs / rt.
REQ-008 D_rs_Tuse / D_rt_Tuse  in  4 each  cycles from D until operand is consumed (5 = unused).
REQ-009 D_Tnew  in  4  cycles from D until result exists (0 = no result).
REQ-010 Stall  out  1  freeze PC and F/D register; insert bubble into E.
REQ-011 Fwd_D_rs / Fwd_D_rt  out  2 each  D-stage operand select: 0 RF, 1 W, 2 M, 3 E.
REQ-012 Fwd_E_rs / Fwd_E_rt  out  2 each  E-stage operand select: 0 pipeline reg, 1 W, 2 M.
REQ-013 Fwd_M_rt  out  1  M-stage store data select: 0 pipeline reg, 1 W.
REQ-014 E_A3, M_A3, W_A3  out  5 each  tracked destination per stage.
REQ-015 Stall_Count  out  16  number of stall cycles since reset.

Function
REQ-016 Tracking state per stage X in {E,M,W}: X_A1, X_A2, X_A3 (5b each), X_Tnew (4b).
REQ-017 Stage advance, Stall=0: E_A1/A2/A3 <= D_A1/A2/A3; E_Tnew <= sat0(D_Tnew-1).
REQ-018 Stage advance, Stall=1: E receives bubble (all E fields <= 0).
REQ-019 Stall-independent: M fields <= E fields with M_Tnew <= sat0(E_Tnew-1); W fields <= M fields with W_Tnew <= sat0(M_Tnew-1).
REQ-020 sat0(x-1) SHALL yield 0 when x=0; no 4-bit wrap to 15.
REQ-021 rs_hit_X = D_A1use & D_A1!=0 & D_A1==X_A3; rt_hit_X is defined likewise with D_A2use, D_A2.
REQ-022 Stall SHALL be combinational: (rs_hit_E & E_Tnew>D_rs_Tuse) | (rs_hit_M & M_Tnew>D_rs_Tuse) | same two terms for rt.
REQ-023 W_Tnew is always 0 at use (register-file write-through), so W SHALL never cause a stall.
REQ-024 Fwd_D_rs SHALL select: 3 if D_A1!=0 & D_A1==E_A3 & E_Tnew==0; else 2 if same vs M; else 1 if same vs W; else 0.
REQ-025 Priority SHALL be E > M > W; the youngest producer wins when several stages share one A3.
REQ-026 Fwd_D_rt SHALL follow REQ-024 using D_A2.
REQ-027 Fwd_E_rs SHALL select: 2 if E_A1!=0 & E_A1==M_A3 & M_Tnew==0; else 1 if same vs W; else 0. Fwd_E_rt is the same using E_A2.
REQ-028 Fwd_M_rt SHALL be 1 iff M_A2!=0 & M_A2==W_A3; else 0.
REQ-029 Register index 0 SHALL never stall and never forward.
REQ-030 Stall_Count SHALL increment by 1 on each rising edge where Stall=1 and reset=1, and saturate at 16'hFFFF.
REQ-031 Latency: all selects and Stall are valid in the same cycle as D inputs, with no registered delay.

Reset
REQ-032 On a rising edge with reset=0: all E/M/W fields <= 0 and Stall_Count <= 0.
REQ-033 After reset: Stall=0, all Fwd_* = 0, E_A3/M_A3/W_A3 = 0.
REQ-034 Reset SHALL dominate Stall mid-operation; the stalled D instruction is discarded with no bubble bookkeeping.
REQ-035 Outputs during reset assertion SHALL reflect the cleared state from the first clock edge onward.

Verification
REQ-036 lw $8 (D_A3=8, D_Tnew=3) then add rs=$8 (Tuse=1) -> 1 stall cycle, Stall_Count=1; next cycle add in D with M_A3=8, Stall=0; add in E gets Fwd_E_rs=1.
REQ-037 add $9 (Tnew=2) then beq rs=$9 (Tuse=0) -> Stall=1 for 1 cycle; next cycle Fwd_D_rs=2.
REQ-038 ori $10 and lui $10 back-to-back, then sw rt=$10 (rt_Tuse=2) -> no stall; sw in E sees Fwd_E_rt=2 (lui in M, younger producer wins).
REQ-039 add $0 (D_A3=0), then beq rs=$0 -> Stall=0, all Fwd_*=0.
REQ-040 lw $8, then jr rs=$8 (Tuse=0) -> Stall high for 2 cycles, Stall_Count=2; then Fwd_D_rs=1.
REQ-041 Assert reset=0 during REQ-040 stall -> next edge clears all fields, Stall=0, Stall_Count=0.
